// File: rtl/rsp_s2_prep_pkg.sv
// Shared constants, mode enum and pipeline tag bundle for the RSP S2 prep path.
// Lane helpers: 17-bit magnitude, mask popcount and hit-count width.
package rsp_s2_prep_pkg;

    localparam int READ_RAM_WIDTH = 128;
    localparam int NUM            = 8;
    localparam int NUM_CPLX       = NUM / 2;
    localparam int DATA_WIDTH     = 16;
    localparam int MAG_W          = DATA_WIDTH + 1;
    localparam int PWR_W          = 2 * DATA_WIDTH;
    localparam int FRAME_LEN      = 64;
    localparam int CNT_W          = $clog2(FRAME_LEN);
    localparam int PC_W           = $clog2(NUM + 1);

    function automatic int hit_cnt_w(input int frame_len, input int lanes);
        return $clog2(frame_len * lanes + 1);
    endfunction

    localparam int HIT_W = hit_cnt_w(FRAME_LEN, NUM);

    typedef enum logic {
        MODE_CPLX = 1'b0,
        MODE_REAL = 1'b1
    } mode_e;

    typedef struct packed {
        logic             vld;
        mode_e            mode;
        logic             sof;
        logic             eof;
        logic             slow;
        logic [PWR_W-1:0] thr;
    } tag_t;

    function automatic logic [MAG_W-1:0] abs_mag(input logic [DATA_WIDTH-1:0] x);
        logic [MAG_W-1:0] ext;
        ext = {x[DATA_WIDTH-1], x};
        return ext[MAG_W-1] ? (~ext + MAG_W'(1)) : ext;
    endfunction

    function automatic logic [PC_W-1:0] popcnt(input logic [NUM-1:0] m);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM; i++) begin
            c = c + PC_W'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/band_lane_power.sv
// Complex lane power I^2 + Q^2: squares registered, then the sum registered.
module band_lane_power
    import rsp_s2_prep_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] re_i,
    input  logic [DATA_WIDTH-1:0] im_i,
    output logic [PWR_W-1:0]      pwr_o
);

    logic signed [PWR_W-1:0] re_sq_d;
    logic signed [PWR_W-1:0] im_sq_d;
    logic [PWR_W-1:0]        re_sq_q;
    logic [PWR_W-1:0]        im_sq_q;
    logic [PWR_W-1:0]        pwr_q;

    // Signed operands widen to 32 bits before the multiply.
    assign re_sq_d = $signed(re_i) * $signed(re_i);
    assign im_sq_d = $signed(im_i) * $signed(im_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_sq_q <= '0;
            im_sq_q <= '0;
            pwr_q   <= '0;
        end else begin
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            pwr_q   <= re_sq_q + im_sq_q;
        end
    end

    assign pwr_o = pwr_q;

endmodule

// File: rtl/band_thresh_cmp.sv
// Per-lane threshold comparator producing real/complex keep masks per band.
// Optional per-frame hit counter built when BAND_THRESH_HITCNT_EN is defined.
module band_thresh_cmp
    import rsp_s2_prep_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_switch,
    input  logic [DATA_WIDTH-1:0]     i_thr_real,
    input  logic [PWR_W-1:0]          i_thr_cplx,
    input  logic                      i_thr_wr,
    input  logic [READ_RAM_WIDTH-1:0] i_x0,
    input  logic                      i_x0_valid,
    input  logic                      i_sof,
    output logic [NUM-1:0]            o_real_cmp,
    output logic                      o_rcmp_valid,
    output logic [NUM_CPLX-1:0]       o_complex_cmp,
    output logic                      o_complex_valid,
    output logic [HIT_W-1:0]          o_hit_cnt,
    output logic                      o_hit_valid
);

    logic [DATA_WIDTH-1:0] shd_real_q;
    logic [PWR_W-1:0]      shd_cplx_q;
    logic [DATA_WIDTH-1:0] act_real_q;
    logic [PWR_W-1:0]      act_cplx_q;
    mode_e                 mode_q;
    logic                  open_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  sof_acc;
    logic                  accept;
    logic                  eof;
    logic [CNT_W-1:0]      cnt_eff;
    mode_e                 mode_cur;
    logic [DATA_WIDTH-1:0] thr_real_cur;
    logic [PWR_W-1:0]      thr_cplx_cur;

    tag_t                  s1_d;
    tag_t                  s1_q;
    tag_t                  s2_q;
    logic [MAG_W-1:0]      mag_q [NUM];
    logic [NUM-1:0]        rmask_s1;
    logic [NUM-1:0]        rmask_q;
    logic [PWR_W-1:0]      pwr [NUM_CPLX];
    logic [NUM_CPLX-1:0]   cmask;

    logic                  r_fast;
    logic                  r_slow;
    logic                  c_out;
    logic [NUM-1:0]        rcmp_q;
    logic                  rvld_q;
    logic [NUM_CPLX-1:0]   ccmp_q;
    logic                  cvld_q;

    assign sof_acc      = i_x0_valid & i_sof;
    assign accept       = i_x0_valid & (i_sof | open_q);
    assign cnt_eff      = sof_acc ? '0 : cnt_q;
    assign eof          = accept & (cnt_eff == CNT_W'(FRAME_LEN - 1));
    assign mode_cur     = sof_acc ? mode_e'(i_switch) : mode_q;
    // The SOF word already sees the threshold it promotes to active.
    assign thr_real_cur = sof_acc ? shd_real_q : act_real_q;
    assign thr_cplx_cur = sof_acc ? shd_cplx_q : act_cplx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_real_q <= '0;
            shd_cplx_q <= '0;
            act_real_q <= '0;
            act_cplx_q <= '0;
            mode_q     <= MODE_REAL;
            open_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (i_thr_wr) begin
                shd_real_q <= i_thr_real;
                shd_cplx_q <= i_thr_cplx;
            end
            if (sof_acc) begin
                act_real_q <= shd_real_q;
                act_cplx_q <= shd_cplx_q;
                mode_q     <= mode_e'(i_switch);
            end
            if (accept) begin
                open_q <= ~eof;
                cnt_q  <= cnt_eff + CNT_W'(1);
            end
        end
    end

    // A real word right behind a complex or delayed word takes one extra
    // register so both mask valids never collide and order is kept.
    always_comb begin
        s1_d      = '0;
        s1_d.vld  = accept;
        s1_d.mode = mode_cur;
        s1_d.sof  = sof_acc;
        s1_d.eof  = eof;
        s1_d.slow = s1_q.vld & ((s1_q.mode == MODE_CPLX) | s1_q.slow);
        s1_d.thr  = (mode_cur == MODE_REAL)
                  ? {{(PWR_W - DATA_WIDTH){1'b0}}, thr_real_cur}
                  : thr_cplx_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            rmask_q <= '0;
            for (int k = 0; k < NUM; k++) begin
                mag_q[k] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            rmask_q <= rmask_s1;
            for (int k = 0; k < NUM; k++) begin
                mag_q[k] <= abs_mag(i_x0[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    for (genvar j = 0; j < NUM_CPLX; j++) begin : g_lane
        band_lane_power u_pwr (
            .clk   (clk),
            .rst_n (rst_n),
            .re_i  (i_x0[2*j*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH]),
            .im_i  (i_x0[2*j*DATA_WIDTH +: DATA_WIDTH]),
            .pwr_o (pwr[j])
        );
    end

    always_comb begin
        rmask_s1 = '0;
        for (int k = 0; k < NUM; k++) begin
            rmask_s1[k] = mag_q[k] >= s1_q.thr[MAG_W-1:0];
        end
    end

    always_comb begin
        cmask = '0;
        for (int j = 0; j < NUM_CPLX; j++) begin
            cmask[j] = pwr[j] >= s2_q.thr;
        end
    end

    assign r_fast = s1_q.vld & (s1_q.mode == MODE_REAL) & ~s1_q.slow;
    assign r_slow = s2_q.vld & (s2_q.mode == MODE_REAL) & s2_q.slow;
    assign c_out  = s2_q.vld & (s2_q.mode == MODE_CPLX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcmp_q <= '0;
            rvld_q <= 1'b0;
            ccmp_q <= '0;
            cvld_q <= 1'b0;
        end else begin
            rvld_q <= r_fast | r_slow;
            rcmp_q <= r_fast ? rmask_s1 : (r_slow ? rmask_q : '0);
            cvld_q <= c_out;
            ccmp_q <= c_out ? cmask : '0;
        end
    end

    assign o_real_cmp      = rcmp_q;
    assign o_rcmp_valid    = rvld_q;
    assign o_complex_cmp   = ccmp_q;
    assign o_complex_valid = cvld_q;

`ifdef BAND_THRESH_HITCNT_EN
    logic             out_sof_q;
    logic             out_eof_q;
    logic [HIT_W-1:0] acc_q;
    logic [HIT_W-1:0] acc_d;
    logic [HIT_W-1:0] hit_cnt_q;
    logic             hit_vld_q;
    logic [PC_W-1:0]  pc;
    logic             out_any;

    assign out_any = rvld_q | cvld_q;
    assign pc      = popcnt(rcmp_q | {{(NUM - NUM_CPLX){1'b0}}, ccmp_q});
    // A new SOF restarts the sum, dropping any aborted partial frame.
    assign acc_d   = (out_sof_q ? '0 : acc_q) + HIT_W'(pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sof_q <= 1'b0;
            out_eof_q <= 1'b0;
            acc_q     <= '0;
            hit_cnt_q <= '0;
            hit_vld_q <= 1'b0;
        end else begin
            out_sof_q <= r_fast ? s1_q.sof : s2_q.sof;
            out_eof_q <= r_fast ? s1_q.eof : s2_q.eof;
            hit_vld_q <= out_any & out_eof_q;
            if (out_any) begin
                acc_q <= acc_d;
            end
            if (out_any & out_eof_q) begin
                hit_cnt_q <= acc_d;
            end
        end
    end

    assign o_hit_cnt   = hit_cnt_q;
    assign o_hit_valid = hit_vld_q;
`else
    logic unused_tags;
    assign unused_tags = ^{s2_q.sof, s2_q.eof};
    assign o_hit_cnt   = '0;
    assign o_hit_valid = 1'b0;
`endif

endmodule

// File: tb/tb_band_thresh_cmp.sv
// Directed scoreboard bench for band_thresh_cmp: stimulus pushes expected
// masks and hit counts, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_band_thresh_cmp;
    import rsp_s2_prep_pkg::*;

    typedef struct {
        int         kind;
        logic [7:0] mask;
        int         due;
    } exp_t;

    typedef struct {
        int cnt;
        int due;
    } hit_t;

    localparam logic [127:0] VR   = {64'h0, 16'h8000, 16'h0063, 16'hFF9B, 16'h0064};
    localparam logic [127:0] V33  = {4{16'hFF39, 16'h00C7, 16'hFF38, 16'h00C8}} >> 0;
    localparam logic [127:0] R150 = {8{16'h0096}};
    localparam logic [127:0] MAXR = {8{16'h7FFF}};
    localparam logic [127:0] VC   = {16'h0000, 16'h0000, 16'hFFFB, 16'h0000,
                                     16'h0003, 16'h0003, 16'h0003, 16'h0004};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_switch = 1'b0;
    logic [15:0]           i_thr_real = '0;
    logic [31:0]           i_thr_cplx = '0;
    logic                  i_thr_wr = 1'b0;
    logic [127:0]          i_x0 = '0;
    logic                  i_x0_valid = 1'b0;
    logic                  i_sof = 1'b0;
    logic [7:0]            o_real_cmp;
    logic                  o_rcmp_valid;
    logic [3:0]            o_complex_cmp;
    logic                  o_complex_valid;
    logic [HIT_W-1:0]      o_hit_cnt;
    logic                  o_hit_valid;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_snap = 0;
    exp_t exp_q[$];
    hit_t hit_q[$];
    exp_t e;
    hit_t h;

    band_thresh_cmp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_switch        (i_switch),
        .i_thr_real      (i_thr_real),
        .i_thr_cplx      (i_thr_cplx),
        .i_thr_wr        (i_thr_wr),
        .i_x0            (i_x0),
        .i_x0_valid      (i_x0_valid),
        .i_sof           (i_sof),
        .o_real_cmp      (o_real_cmp),
        .o_rcmp_valid    (o_rcmp_valid),
        .o_complex_cmp   (o_complex_cmp),
        .o_complex_valid (o_complex_valid),
        .o_hit_cnt       (o_hit_cnt),
        .o_hit_valid     (o_hit_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic sof, input logic sw,
                        input logic [127:0] d, input logic wr, input int kind,
                        input logic [7:0] m, input int lat, input int hit);
        @(negedge clk);
        i_x0_valid = v;
        i_sof      = sof;
        i_switch   = sw;
        i_x0       = d;
        i_thr_wr   = wr;
        if (kind != 0) exp_q.push_back('{kind, m, cyc + lat});
`ifdef BAND_THRESH_HITCNT_EN
        if (hit >= 0) hit_q.push_back('{hit, cyc + lat + 1});
`else
        if (hit < -1) $display("bad hit arg %0d", hit);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 8'h0, 0, -1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rvld"}, o_rcmp_valid, 0);
        chk({tag, "_rmask"}, o_real_cmp, 0);
        chk({tag, "_cvld"}, o_complex_valid, 0);
        chk({tag, "_cmask"}, o_complex_cmp, 0);
        chk({tag, "_hvld"}, o_hit_valid, 0);
        chk({tag, "_hcnt"}, o_hit_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rcmp_valid || o_complex_valid) begin
                n_out++;
                chk("both_valid", o_rcmp_valid & o_complex_valid, 0);
                chk("exp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_kind", o_rcmp_valid ? 1 : 2, e.kind);
                    chk("out_mask", o_rcmp_valid ? o_real_cmp : {4'h0, o_complex_cmp}, e.mask);
                    chk("out_cycle", cyc, e.due);
                    chk("other_mask", o_rcmp_valid ? {4'h0, o_complex_cmp} : o_real_cmp, 0);
                end
            end
`ifdef BAND_THRESH_HITCNT_EN
            if (o_hit_valid) begin
                chk("hit_pending", hit_q.size() != 0, 1);
                if (hit_q.size() != 0) begin
                    h = hit_q.pop_front();
                    chk("hit_cnt", o_hit_cnt, h.cnt);
                    chk("hit_cycle", cyc, h.due);
                end
            end
`else
            chk("hit_off", {o_hit_valid, o_hit_cnt}, 0);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        // Valid words before any SOF are dropped.
        for (int k = 0; k < 3; k++) step(1, 0, 1, MAXR, 0, 0, 8'h0, 0, -1);

        i_thr_real = 16'd100;
        i_thr_cplx = 32'd25;
        step(0, 0, 0, '0, 1, 0, 8'h0, 0, -1);
        idle(1);

        // F1: real, threshold rewritten at word 5 stays old for this frame.
        for (int k = 0; k < 64; k++) begin
            if (k == 5) i_thr_real = 16'd200;
            step(1, k == 0, 1, k == 0 ? VR : (k < 6 ? 128'h0 : R150), k == 5, 1,
                 k == 0 ? 8'h0B : (k < 6 ? 8'h00 : 8'hFF), 2, k == 63 ? 467 : -1);
        end

        // F2: new threshold from SOF, aborted after 10 words.
        for (int k = 0; k < 10; k++)
            step(1, k == 0, 1, k == 0 ? V33 : MAXR, 0, 1,
                 k == 0 ? 8'h33 : 8'hFF, 2, -1);

        // F3: full frame of max words.
        for (int k = 0; k < 64; k++) begin
            if (k == 20) begin
                i_thr_real = 16'd100;
                i_thr_cplx = 32'd25;
            end
            step(1, k == 0, 1, MAXR, k == 20, 1, 8'hFF, 2, k == 63 ? 512 : -1);
        end

        // F4: complex; shadow written on SOF must not apply yet.
        i_thr_cplx = 32'd1000;
        for (int k = 0; k < 64; k++)
            step(1, k == 0, k == 1, k == 0 ? VC : (k == 1 ? 128'h5 : 128'h0),
                 k == 0, 2, k == 0 ? 8'h05 : (k == 1 ? 8'h01 : 8'h00), 3,
                 k == 63 ? 3 : -1);

        // F5: real right behind complex takes the delayed path.
        for (int k = 0; k < 64; k++)
            step(1, k == 0, 1, k == 0 ? VR : 128'h0, 0, 1,
                 k == 0 ? 8'h0B : 8'h00, 3, k == 63 ? 3 : -1);
        for (int k = 0; k < 2; k++) step(1, 0, 1, MAXR, 0, 0, 8'h0, 0, -1);
        idle(6);
`ifdef BAND_THRESH_HITCNT_EN
        chk("hit_hold", o_hit_cnt, 3);
`else
        chk("hit_hold", o_hit_cnt, 0);
`endif
        chk("outs_seen", n_out, 266);

        // F6: complex, reset during word 5.
        for (int k = 0; k < 5; k++)
            step(1, k == 0, 0, 128'h0, 0, 2, 8'h00, 3, -1);
        @(negedge clk);
        i_x0_valid = 1'b1;
        i_sof      = 1'b0;
        i_x0       = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        exp_q.delete();
        hit_q.delete();
        n_snap = n_out;
        repeat (2) @(negedge clk);
        chk("mrst_hold_rvld", o_rcmp_valid, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step(1, 0, 1, MAXR, 0, 0, 8'h0, 0, -1);
        idle(6);
        chk("post_rst_outs", n_out, n_snap);
        chk("post_rst_hcnt", o_hit_cnt, 0);

        idle(4);
        chk("exp_drained", exp_q.size(), 0);
        chk("hit_drained", hit_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
